// File: rtl/kid_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kid_pkg
// Purpose  : Shared definitions for the kid sprite: motion state encoding,
//            PS/2 key codes and per-pose sprite dimensions. Imported by the
//            motion controller, its key decoder and the kid renderer.
// Revision : 1.0 - initial release
// ============================================================================
package kid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_JUMP = 3'd2,
        ST_FALL = 3'd3,
        ST_DEAD = 3'd4
    } kid_state_t;

    localparam logic [7:0] c_key_none    = 8'h00;
    localparam logic [7:0] c_key_left    = 8'h6B;
    localparam logic [7:0] c_key_right   = 8'h74;
    localparam logic [7:0] c_key_jump    = 8'h12;
    localparam logic [7:0] c_key_respawn = 8'h2D;

    // Sprite sizes per pose (width x height, pixels)
    localparam int c_run_w  = 26;
    localparam int c_run_h  = 23;
    localparam int c_jump_w = 18;
    localparam int c_jump_h = 23;
    localparam int c_fall_w = 27;
    localparam int c_fall_h = 20;

endpackage

`default_nettype wire

// File: rtl/kid_key_decode.sv
`default_nettype none
// ============================================================================
// Module   : kid_key_decode
// Purpose  : Registers the held keycode, exposes left/right/respawn levels
//            and latches jump press / jump release events until the next
//            update tick consumes them.
// Ports    : clk, rst_n          clock, async active-low reset
//            i_keycode[7:0]      currently held key
//            i_tick_clr          update tick, clears both latched requests
//            o_left/o_right      direction key held (registered)
//            o_respawn           respawn key held (registered)
//            o_jump_req          jump pressed since last tick
//            o_rel_req           jump released since last tick
// Revision : 1.0 - initial release
// ============================================================================
module kid_key_decode
    import kid_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_keycode,
    input  logic       i_tick_clr,
    output logic       o_left,
    output logic       o_right,
    output logic       o_respawn,
    output logic       o_jump_req,
    output logic       o_rel_req
);

    logic [7:0] r_key;
    logic       r_jump_req;
    logic       r_rel_req;
    logic       w_press;
    logic       w_release;

    assign w_press   = (i_keycode == c_key_jump) && (r_key != c_key_jump);
    assign w_release = (i_keycode != c_key_jump) && (r_key == c_key_jump);

    // A new edge on the same clk as the consuming tick must survive for the
    // following tick, so set has priority over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key      <= c_key_none;
            r_jump_req <= 1'b0;
            r_rel_req  <= 1'b0;
        end else begin
            r_key <= i_keycode;
            if (w_press)
                r_jump_req <= 1'b1;
            else if (i_tick_clr)
                r_jump_req <= 1'b0;
            if (w_release)
                r_rel_req <= 1'b1;
            else if (i_tick_clr)
                r_rel_req <= 1'b0;
        end
    end

    assign o_left     = (r_key == c_key_left);
    assign o_right    = (r_key == c_key_right);
    assign o_respawn  = (r_key == c_key_respawn);
    assign o_jump_req = r_jump_req;
    assign o_rel_req  = r_rel_req;

endmodule

`default_nettype wire

// File: rtl/kid_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : kid_motion_ctrl
// Purpose  : Per-frame motion controller for the kid sprite. Runs the
//            idle/run/jump/fall/dead sequencing, integrates vertical velocity
//            under gravity and registers position, facing and run frame.
// Ports    : clk, rst_n      clock, async active-low reset
//            update_tick     one-clk pulse per frame
//            keycode[7:0]    held PS/2 key, 8'h00 = none
//            solid_below     solid tile directly under the feet
//            hit             kid overlaps a hazard
//            kid_x/kid_y     top-left position
//            kid_state[2:0]  IDLE/RUN/JUMP/FALL/DEAD
//            facing          0 = right, 1 = left
//            anim_frame[1:0] run-cycle frame
// Revision : 1.0 - initial release
// ============================================================================
module kid_motion_ctrl
    import kid_pkg::*;
#(
    parameter int INIT_X    = 60,
    parameter int INIT_Y    = 558,
    parameter int SCREEN_W  = 800,
    parameter int KID_W     = 26,
    parameter int RUN_SPEED = 3,
    parameter int JUMP_V    = 8,
    parameter int DJUMP_V   = 7,
    parameter int GRAVITY   = 1,
    parameter int MAX_FALL  = 9,
    parameter int ANIM_DIV  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       update_tick,
    input  logic [7:0] keycode,
    input  logic       solid_below,
    input  logic       hit,
    output logic [9:0] kid_x,
    output logic [9:0] kid_y,
    output logic [2:0] kid_state,
    output logic       facing,
    output logic [1:0] anim_frame
);

    localparam logic signed [11:0] c_init_x  = 12'(INIT_X);
    localparam logic signed [11:0] c_init_y  = 12'(INIT_Y);
    localparam logic signed [11:0] c_x_max   = 12'(SCREEN_W - KID_W);
    localparam logic signed [11:0] c_run     = 12'(RUN_SPEED);
    localparam logic signed [5:0]  c_jump_v  = 6'(JUMP_V);
    localparam logic signed [5:0]  c_djump_v = 6'(DJUMP_V);
    localparam logic signed [5:0]  c_gravity = 6'(GRAVITY);
    localparam logic signed [5:0]  c_max_fall = 6'(MAX_FALL);
    localparam int                 c_cnt_w   = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(ANIM_DIV - 1);

    logic w_left, w_right, w_respawn, w_jump_req, w_rel_req;

    kid_key_decode u_key_decode (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_keycode  (keycode),
        .i_tick_clr (update_tick),
        .o_left     (w_left),
        .o_right    (w_right),
        .o_respawn  (w_respawn),
        .o_jump_req (w_jump_req),
        .o_rel_req  (w_rel_req)
    );

    kid_state_t          r_state, w_state;
    logic [9:0]          r_x, r_y, w_x, w_y;
    logic signed [5:0]   r_vy, w_vy, w_vg;
    logic [1:0]          r_jumps, w_jumps;
    logic                r_facing, w_facing;
    logic [1:0]          r_anim, w_anim;
    logic [c_cnt_w-1:0]  r_anim_cnt, w_anim_cnt;
    logic                w_was_air, w_air;
    logic signed [11:0]  w_xsum, w_ysum;

    assign w_was_air = (r_state == ST_JUMP) || (r_state == ST_FALL);

    // Rules are applied in strict priority order; "airborne" for the vertical
    // step includes a jump launched earlier in the same tick.
    always_comb begin
        w_x      = r_x;
        w_y      = r_y;
        w_vy     = r_vy;
        w_vg     = '0;
        w_jumps  = r_jumps;
        w_state  = r_state;
        w_facing = r_facing;
        w_air    = 1'b0;
        w_xsum   = '0;
        w_ysum   = '0;
        if (w_respawn) begin
            w_x      = c_init_x[9:0];
            w_y      = c_init_y[9:0];
            w_vy     = '0;
            w_jumps  = 2'd2;
            w_facing = 1'b0;
            w_state  = ST_IDLE;
        end else if (r_state == ST_DEAD) begin
            w_state = ST_DEAD;
        end else if (hit) begin
            w_state = ST_DEAD;
            w_vy    = '0;
        end else begin
            w_air = w_was_air;
            if (w_left || w_right) begin
                w_xsum = w_left ? ($signed({2'b00, r_x}) - c_run)
                                : ($signed({2'b00, r_x}) + c_run);
                if (w_xsum < 0)
                    w_x = '0;
                else if (w_xsum > c_x_max)
                    w_x = c_x_max[9:0];
                else
                    w_x = w_xsum[9:0];
                w_facing = w_left;
            end
            if (w_jump_req && (r_jumps != 2'd0)) begin
                w_vy    = w_was_air ? -c_djump_v : -c_jump_v;
                w_jumps = r_jumps - 2'd1;
                w_air   = 1'b1;
            end
            if (w_rel_req && (w_vy < 0))
                w_vy = w_vy >>> 1;
            if (w_air) begin
                w_vg = w_vy + c_gravity;
                if (w_vg > c_max_fall)
                    w_vg = c_max_fall;
                w_vy   = w_vg;
                w_ysum = $signed({2'b00, r_y}) + {{6{w_vy[5]}}, w_vy};
                if (w_ysum < 0) begin
                    w_y  = '0;
                    w_vy = '0;
                end else if ((w_vy > 0) && ((w_ysum >= c_init_y) || solid_below)) begin
                    w_y     = (w_ysum >= c_init_y) ? c_init_y[9:0] : w_ysum[9:0];
                    w_vy    = '0;
                    w_jumps = 2'd2;
                    w_air   = 1'b0;
                end else begin
                    w_y = w_ysum[9:0];
                end
            end else if (!solid_below && ($signed({2'b00, r_y}) < c_init_y)) begin
                // Walked off a ledge: start falling next tick with one air jump.
                w_air   = 1'b1;
                w_jumps = 2'd1;
            end
            if (w_air)
                w_state = (w_vy < 0) ? ST_JUMP : ST_FALL;
            else
                w_state = (w_left || w_right) ? ST_RUN : ST_IDLE;
        end
    end

    // Run frame advances every ANIM_DIV consecutive RUN ticks; entering RUN
    // restarts the cycle at frame 0.
    always_comb begin
        w_anim     = '0;
        w_anim_cnt = '0;
        if ((w_state == ST_RUN) && (r_state == ST_RUN)) begin
            if (r_anim_cnt == c_cnt_last) begin
                w_anim_cnt = '0;
                w_anim     = r_anim + 2'd1;
            end else begin
                w_anim_cnt = r_anim_cnt + 1'b1;
                w_anim     = r_anim;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_x        <= c_init_x[9:0];
            r_y        <= c_init_y[9:0];
            r_vy       <= '0;
            r_jumps    <= 2'd2;
            r_facing   <= 1'b0;
            r_anim     <= '0;
            r_anim_cnt <= '0;
        end else if (update_tick) begin
            r_state    <= w_state;
            r_x        <= w_x;
            r_y        <= w_y;
            r_vy       <= w_vy;
            r_jumps    <= w_jumps;
            r_facing   <= w_facing;
            r_anim     <= w_anim;
            r_anim_cnt <= w_anim_cnt;
        end
    end

    assign kid_x      = r_x;
    assign kid_y      = r_y;
    assign kid_state  = r_state;
    assign facing     = r_facing;
    assign anim_frame = r_anim;

endmodule

`default_nettype wire
